sram_burst_controller: RTL
==========================

Name: sram_burst_controller

Overview:
Parametrised controller for asynchronous single-port SRAM (default 256K x 16), between the image-pipeline user logic and the external SRAM pins.
- User side: valid/ready command channel with burst length, a separate write-data channel with byte enables, and a read-data strobe.
- SRAM side: programmable access, setup, pulse and bus-turnaround timing, per-byte lane enables, and a split tristate (dq_o/dq_oe/dq_i) for the top-level pad.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, data width; must be a multiple of 8. BE_W = DATA_W/8 is derived.
- RD_WAIT, 11, read access cycles per beat; range 1..255.
- WR_SETUP, 1, cycles from address/data valid to we_n fall; range 1..255.
- WR_PULSE, 5, we_n low cycles per beat; range 1..255.
- TURNAROUND, 1, idle cycles with bus released after every command; range 1..255.
- MAX_BURST, 16, maximum beats per command. LEN_W = clog2(MAX_BURST) is derived.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when high with req_valid
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  start address
- req_len  in  LEN_W  beats minus 1
- wdata_valid  in  1  write beat valid
- wdata_ready  out  1  write beat accepted
- wdata  in  DATA_W  write data
- wdata_be  in  BE_W  byte enables, active-high
- rdata_valid  out  1  one-cycle read strobe
- rdata  out  DATA_W  read data
- wr_done  out  1  one-cycle pulse when the final write beat completes
- busy  out  1  state != IDLE
- sram_addr  out  ADDR_W  SRAM address
- sram_dq_o  out  DATA_W  data to pad
- sram_dq_oe  out  1  pad drive enable
- sram_dq_i  in  DATA_W  data from pad
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM control pins, active-low
- sram_be_n  out  BE_W  SRAM byte-lane enables, active-low

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - req_ready=0 while rst is high.
  - Remaining outputs, held while rst is high and from the first edge with rst low: state IDLE; req_ready=1 from that first edge; wdata_ready=0; rdata_valid=0; wr_done=0; busy=0; rdata=0; sram_addr=0; sram_dq_o=0; sram_dq_oe=0; ce_n/oe_n/we_n=1; be_n all 1.
  - All outputs are registered.
- Reset mid-operation: the burst is abandoned on the reset edge. No further rdata_valid or wr_done is produced. Pins go to idle values at that edge.
- States: IDLE, RD_ACCESS, WR_DATA, WR_SETUP, WR_PULSE, WR_HOLD, TURNAROUND.
- IDLE:
  - req_ready=1.
  - On the handshake at edge T: latch addr, we and len into the address register and beat counter.
  - Next state is RD_ACCESS (read) or WR_DATA (write).
  - req_ready is low in every other state, so there is no command queuing.
- RD_ACCESS:
  - ce_n=0, oe_n=0, be_n=0, dq_oe=0, for RD_WAIT cycles (T+1..T+RD_WAIT).
  - On the last cycle's edge, sram_dq_i is latched into rdata; rdata_valid is high for the following cycle.
  - If beats remain: address +1, counter reloads, stay in RD_ACCESS with oe_n held low. One beat every RD_WAIT cycles.
  - Otherwise go to TURNAROUND.
  - There is no rdata backpressure; the consumer must accept every strobe.
- WR_DATA:
  - wdata_ready=1; ce_n=1; dq_oe=0.
  - On wdata_valid, latch wdata and wdata_be, then go to WR_SETUP. A stall of any length is legal.
  - wdata_valid in any other state is ignored.
- WR_SETUP: ce_n=0, oe_n=1, we_n=1, dq_oe=1, sram_dq_o = latched data, be_n = ~latched be. Lasts WR_SETUP cycles.
- WR_PULSE: as WR_SETUP but we_n=0. Lasts WR_PULSE cycles.
- WR_HOLD:
  - we_n=1; data, address and dq_oe held. Lasts 1 cycle.
  - If beats remain: address +1, go to WR_DATA.
  - Otherwise: wr_done is high in the next cycle, go to TURNAROUND.
- TURNAROUND: all control pins high, dq_oe=0, for TURNAROUND cycles, then IDLE.
- Invariants:
  - dq_oe and !oe_n are never both high.
  - we_n changes only while address and data are stable.
- Address wrap: increments are modulo 2^ADDR_W (the maximum address wraps to 0).
- Single-read latency: handshake at T, rdata_valid at T+RD_WAIT+1, req_ready high again at T+RD_WAIT+TURNAROUND+1.
- Internal counters: 8-bit wait counter, LEN_W-bit beat counter.

Decomposition:
- Package sram_ctrl_pkg holds:
  - the state enum sram_state_t;
  - control-pin encodings for {ce_n, oe_n, we_n}: CTRL_IDLE=3'b111, CTRL_READ=3'b001, CTRL_WRITE_SETUP=3'b011, CTRL_WRITE_PULSE=3'b010;
  - a clog2 helper.
- Sub-module sram_cycle_timer: load value, count-down, done flag. Instantiated once and shared by all timed states.

Test Plan:
- Defaults; read len=0 at 0x00010; SRAM model returns 0xBEEF -> oe_n low T+1..T+11; rdata_valid only at T+12 with 0xBEEF; req_ready at T+13.
- Write len=3 at 0x3FFFE, data A1..A4, be=2'b11 -> sram_addr 0x3FFFE, 0x3FFFF, 0x00000, 0x00001; we_n low for exactly 5 cycles per beat; single wr_done; model holds A1..A4.
- Write be=2'b01, data 0x1234 over existing 0xFFFF -> be_n=2'b10 during pulse; location reads back 0xFF34.
- Write immediately followed by read (req_valid held high) -> dq_oe low for at least 1 cycle before oe_n falls; assertion (dq_oe && !oe_n) never fires.
- rst raised after the first beat of a 4-beat read -> next cycle: all pins idle, no further rdata_valid; req_ready=1 on the first edge after rst drops.
- wdata_valid held low for 7 cycles in WR_DATA -> ce_n/we_n stay 1 and dq_oe=0 throughout; the beat proceeds normally once valid rises.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the asynchronous SRAM burst controller.
//   sram_state_t      controller FSM state encoding
//   CTRL_*            {ce_n, oe_n, we_n} pin encodings for each bus phase
//   clog2()           ceiling log2, used to size the beat counter
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ACCESS,
    ST_WR_DATA,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_TURNAROUND
  } sram_state_t;

  // Control pin patterns, ordered {ce_n, oe_n, we_n}
  localparam logic [2:0] CTRL_IDLE        = 3'b111;
  localparam logic [2:0] CTRL_READ        = 3'b001;
  localparam logic [2:0] CTRL_WRITE_SETUP = 3'b011;
  localparam logic [2:0] CTRL_WRITE_PULSE = 3'b010;

  // Ceiling log2; clog2(16) = 4, clog2(17) = 5
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_cycle_timer.sv
// ---------------------------------------------------------------------------
// sram_cycle_timer
// Shared down-counter that times every bus phase of the SRAM controller.
// Loading N-1 on entry to a phase makes done_o rise after N cycles in it.
//   clk         clock
//   rst         synchronous active-high reset
//   load_i      load load_val_i this cycle (takes priority over counting)
//   load_val_i  cycles-minus-one for the phase being entered
//   done_o      counter has reached zero
// ---------------------------------------------------------------------------
module sram_cycle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       done_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Load wins over counting so a phase can restart on the same edge it ends;
  // the counter parks at zero once expired.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != 8'd0) begin
      count_d = count_q - 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == 8'd0);

endmodule

// File: rtl/sram_burst_controller.sv
// ---------------------------------------------------------------------------
// sram_burst_controller
// Burst controller for an asynchronous single-port SRAM.
//   clk, rst                  clock, synchronous active-high reset
//   req_*                     command channel (valid/ready, we, addr, len-1)
//   wdata_*                   write beat channel with byte enables
//   rdata_valid, rdata        one-cycle read strobe and data
//   wr_done                   pulse after the last write beat of a command
//   busy                      controller not idle
//   sram_addr, sram_dq_o/oe/i address and split tristate data bus
//   sram_ce_n/oe_n/we_n/be_n  active-low SRAM controls
// All outputs are registered: output values are decoded from the next state
// and captured on the same edge as the state register.
// ---------------------------------------------------------------------------
module sram_burst_controller
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int RD_WAIT    = 11,
  parameter int WR_SETUP   = 1,
  parameter int WR_PULSE   = 5,
  parameter int TURNAROUND = 1,
  parameter int MAX_BURST  = 16,
  localparam int BE_W      = DATA_W / 8,
  localparam int LEN_W     = (MAX_BURST > 1) ? clog2(MAX_BURST) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   wdata_be,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              wr_done,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [BE_W-1:0]   sram_be_n
);

  // Timer reload values are cycles-minus-one
  localparam logic [7:0] RD_LOAD    = 8'(RD_WAIT - 1);
  localparam logic [7:0] SETUP_LOAD = 8'(WR_SETUP - 1);
  localparam logic [7:0] PULSE_LOAD = 8'(WR_PULSE - 1);
  localparam logic [7:0] TA_LOAD    = 8'(TURNAROUND - 1);

  sram_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [BE_W-1:0]   wbe_q, wbe_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              wr_done_q, wr_done_d;
  logic              req_ready_q, req_ready_d;
  logic              wdata_ready_q, wdata_ready_d;
  logic              busy_q, busy_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              dq_oe_q, dq_oe_d;
  logic [BE_W-1:0]   be_n_q, be_n_d;

  logic              timer_load;
  logic [7:0]        timer_val;
  logic              timer_done;

  sram_cycle_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .done_o     (timer_done)
  );

  // Next-state logic. len_q holds beats remaining minus one, so zero marks
  // the final beat. Address increments wrap naturally at 2^ADDR_W.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    wdat_d        = wdat_q;
    wbe_d         = wbe_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    wr_done_d     = 1'b0;
    timer_load    = 1'b0;
    timer_val     = 8'd0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d = req_addr;
          len_d  = req_len;
          if (req_we) begin
            state_d = ST_WR_DATA;
          end else begin
            state_d    = ST_RD_ACCESS;
            timer_load = 1'b1;
            timer_val  = RD_LOAD;
          end
        end
      end
      ST_RD_ACCESS: begin
        if (timer_done) begin
          rdata_d       = sram_dq_i;
          rdata_valid_d = 1'b1;
          timer_load    = 1'b1;
          if (len_q != '0) begin
            len_d     = len_q - LEN_W'(1);
            addr_d    = addr_q + ADDR_W'(1);
            timer_val = RD_LOAD;
          end else begin
            state_d   = ST_TURNAROUND;
            timer_val = TA_LOAD;
          end
        end
      end
      ST_WR_DATA: begin
        if (wdata_valid && wdata_ready_q) begin
          wdat_d     = wdata;
          wbe_d      = wdata_be;
          state_d    = ST_WR_SETUP;
          timer_load = 1'b1;
          timer_val  = SETUP_LOAD;
        end
      end
      ST_WR_SETUP: begin
        if (timer_done) begin
          state_d    = ST_WR_PULSE;
          timer_load = 1'b1;
          timer_val  = PULSE_LOAD;
        end
      end
      ST_WR_PULSE: begin
        if (timer_done) begin
          state_d = ST_WR_HOLD;
        end
      end
      ST_WR_HOLD: begin
        // Address only moves after we_n has already risen here
        if (len_q != '0) begin
          len_d   = len_q - LEN_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_WR_DATA;
        end else begin
          wr_done_d  = 1'b1;
          state_d    = ST_TURNAROUND;
          timer_load = 1'b1;
          timer_val  = TA_LOAD;
        end
      end
      ST_TURNAROUND: begin
        if (timer_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered pins line up with
  // the state they belong to. The bus is only driven in the three write
  // phases, and oe_n is only low in RD_ACCESS, so they can never overlap.
  always_comb begin
    req_ready_d   = 1'b0;
    wdata_ready_d = 1'b0;
    busy_d        = (state_d != ST_IDLE);
    ctrl_d        = CTRL_IDLE;
    dq_oe_d       = 1'b0;
    be_n_d        = '1;
    case (state_d)
      ST_IDLE: begin
        req_ready_d = 1'b1;
      end
      ST_RD_ACCESS: begin
        ctrl_d = CTRL_READ;
        be_n_d = '0;
      end
      ST_WR_DATA: begin
        wdata_ready_d = 1'b1;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        ctrl_d  = CTRL_WRITE_SETUP;
        dq_oe_d = 1'b1;
        be_n_d  = ~wbe_d;
      end
      ST_WR_PULSE: begin
        ctrl_d  = CTRL_WRITE_PULSE;
        dq_oe_d = 1'b1;
        be_n_d  = ~wbe_d;
      end
      default: begin
        ctrl_d = CTRL_IDLE;
      end
    endcase
  end

  // State and output registers. Reset abandons any burst on the edge it is
  // seen and parks the pins idle; req_ready comes up on the first edge after.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      wdat_q        <= '0;
      wbe_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      wr_done_q     <= 1'b0;
      req_ready_q   <= 1'b0;
      wdata_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      ctrl_q        <= CTRL_IDLE;
      dq_oe_q       <= 1'b0;
      be_n_q        <= '1;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      wdat_q        <= wdat_d;
      wbe_q         <= wbe_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      wr_done_q     <= wr_done_d;
      req_ready_q   <= req_ready_d;
      wdata_ready_q <= wdata_ready_d;
      busy_q        <= busy_d;
      ctrl_q        <= ctrl_d;
      dq_oe_q       <= dq_oe_d;
      be_n_q        <= be_n_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign wdata_ready = wdata_ready_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_q;
  assign wr_done     = wr_done_q;
  assign busy        = busy_q;
  assign sram_addr   = addr_q;
  assign sram_dq_o   = wdat_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_be_n   = be_n_q;
  assign {sram_ce_n, sram_oe_n, sram_we_n} = ctrl_q;

endmodule
